// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default sizing and counter widths.
// Optional drop counter is selected by RST_SEQ_DROP_CNT_EN (see rst_seq_ctrl.sv).
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStage = 2'b01,
        StRun   = 2'b10,
        StHold  = 2'b11
    } seq_state_e;

    localparam int unsigned NumStageDflt = 3;
    localparam int unsigned StageDlyDflt = 16;
    localparam int unsigned LinkDbncDflt = 8;
    localparam int unsigned SoftHoldDflt = 64;
    localparam int unsigned DropCntW     = 8;

    // One shared cycle counter serves both the stage spacing and the hold timer.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Link/soft-reset handshake and per-subsystem reset bundle between the sequencer and its users.
interface rst_seq_ctrl_if
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGE = NumStageDflt
);

    logic                 smlh_link_up;
    logic                 soft_rst_req;
    logic                 soft_rst_ack;
    logic [NUM_STAGE-1:0] stage_rst_n;
    logic                 sys_ready;
    logic [DropCntW-1:0]  link_drop_cnt;

    modport master (
        output smlh_link_up, soft_rst_req,
        input  soft_rst_ack, stage_rst_n, sys_ready, link_drop_cnt
    );

    modport slave (
        input  smlh_link_up, soft_rst_req,
        output soft_rst_ack, stage_rst_n, sys_ready, link_drop_cnt
    );

endinterface

// File: rtl/rst_seq_ctrl_link_dbnc.sv
// 2-FF synchronizer for the asynchronous PCIe link-up plus a rise-only debounce producing link_ok_o.
module rst_seq_ctrl_link_dbnc #(
    parameter int unsigned LINK_DBNC = 8
) (
    input  logic core_clk,
    input  logic core_rst,
    input  logic link_async_i,
    output logic link_ok_o
);

    localparam int unsigned DbncW = $clog2(LINK_DBNC + 1);

    logic             sync1_q, sync2_q;
    logic [DbncW-1:0] dbnc_q, dbnc_d;
    logic             link_ok_q, link_ok_d;

    // Any synchronized low clears the run length and drops link_ok on the next edge.
    always_comb begin
        dbnc_d = dbnc_q;
        if (!sync2_q) begin
            dbnc_d = '0;
        end else if (dbnc_q != DbncW'(LINK_DBNC)) begin
            dbnc_d = dbnc_q + 1'b1;
        end
        link_ok_d = sync2_q && (dbnc_q == DbncW'(LINK_DBNC));
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dbnc_q    <= '0;
            link_ok_q <= 1'b0;
        end else begin
            sync1_q   <= link_async_i;
            sync2_q   <= sync1_q;
            dbnc_q    <= dbnc_d;
            link_ok_q <= link_ok_d;
        end
    end

    assign link_ok_o = link_ok_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered per-subsystem reset release gated by PCIe link-up, with soft-reset handshake.
// Define RST_SEQ_DROP_CNT_EN to build the saturating link-drop counter; otherwise it reads 0.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGE = NumStageDflt,
    parameter int unsigned STAGE_DLY = StageDlyDflt,
    parameter int unsigned LINK_DBNC = LinkDbncDflt,
    parameter int unsigned SOFT_HOLD = SoftHoldDflt
) (
    input logic           core_clk,
    input logic           core_rst,
    rst_seq_ctrl_if.slave seq_if
);

    localparam int unsigned CntW = cnt_width(STAGE_DLY, SOFT_HOLD);
    localparam int unsigned StgW = $clog2(NUM_STAGE + 1);

    seq_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [StgW-1:0]      stg_q, stg_d;
    logic [NUM_STAGE-1:0] stage_q, stage_d;
    logic                 req_q, req_d, req_prev_q, req_new;
    logic                 ack_q, ack_d, rdy_q, rdy_d;
    logic                 link_ok;

    rst_seq_ctrl_link_dbnc #(
        .LINK_DBNC (LINK_DBNC)
    ) u_link_dbnc (
        .core_clk     (core_clk),
        .core_rst     (core_rst),
        .link_async_i (seq_if.smlh_link_up),
        .link_ok_o    (link_ok)
    );

    // Only a fresh rising edge counts, so a request still held after ack cannot retrigger.
    assign req_new = seq_if.soft_rst_req & ~req_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        stage_d = stage_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                stage_d = '0;
                stg_d   = '0;
                cnt_d   = '0;
                if (req_new) begin
                    state_d = StHold;
                    req_d   = 1'b1;
                end else if (link_ok) begin
                    state_d = StStage;
                end
            end
            StStage, StRun: begin
                if (!link_ok || req_new) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    stage_d = '0;
                    req_d   = req_new;
                end else if (state_q == StStage) begin
                    if (stg_q == StgW'(NUM_STAGE)) begin
                        state_d = StRun;
                    end else if (cnt_q == CntW'(STAGE_DLY - 1)) begin
                        cnt_d = '0;
                        stg_d = stg_q + 1'b1;
                        for (int unsigned k = 0; k < NUM_STAGE; k++) begin
                            if (stg_q == StgW'(k)) stage_d[k] = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                // Late requests and drops fold into this hold without restarting the timer.
                stage_d = '0;
                if (req_new) req_d = 1'b1;
                if (cnt_q == CntW'(SOFT_HOLD - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        ack_d = (state_d == StHold) && (cnt_d == CntW'(SOFT_HOLD - 1)) && req_d;
        rdy_d = (state_d == StRun);
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            stg_q      <= '0;
            stage_q    <= '0;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
            stage_q    <= stage_d;
            req_q      <= req_d;
            req_prev_q <= seq_if.soft_rst_req;
            ack_q      <= ack_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef RST_SEQ_DROP_CNT_EN
    logic                drop;
    logic [DropCntW-1:0] drop_cnt_q;

    assign drop = ((state_q == StStage) || (state_q == StRun)) && !link_ok;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign seq_if.link_drop_cnt = drop_cnt_q;
`else
    assign seq_if.link_drop_cnt = '0;
`endif

    assign seq_if.stage_rst_n  = stage_q;
    assign seq_if.sys_ready    = rdy_q;
    assign seq_if.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: vector table, directed corner sequences and random stimulus
// against a timestamp-based reference model. Honours RST_SEQ_DROP_CNT_EN for drop-count expectations.
module tb_rst_seq_ctrl;

    localparam int unsigned NS = 3;
    localparam int unsigned SD = 16;
    localparam int unsigned LD = 8;
    localparam int unsigned SH = 64;
`ifdef RST_SEQ_DROP_CNT_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    localparam int PIdle = 0;
    localparam int PSeq  = 1;
    localparam int PRun  = 2;
    localparam int PHold = 3;

    logic core_clk = 1'b0;
    logic core_rst = 1'b0;

    rst_seq_ctrl_if #(.NUM_STAGE(NS)) seq_if ();

    rst_seq_ctrl #(
        .NUM_STAGE (NS),
        .STAGE_DLY (SD),
        .LINK_DBNC (LD),
        .SOFT_HOLD (SH)
    ) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .seq_if   (seq_if)
    );

    always #5 core_clk = ~core_clk;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    // Reference model: phase plus the edge index at which it was entered.
    int          m_phase;
    int          m_t0;
    int          m_n;
    int          m_drops;
    bit          m_latched;
    bit          m_lok;
    bit          m_req_prev;
    bit [31:0]   m_hist;
    bit [NS-1:0] e_stage;
    bit          e_rdy;
    bit          e_ack;

    typedef struct {
        bit          link;
        bit          req;
        int unsigned ticks;
        bit [NS-1:0] stage;
        bit          rdy;
        bit          ack;
        int          drops;
    } vec_t;

    vec_t vecs[18];

    function automatic int exp_drop(int n);
        int cap;
        cap = (n > 255) ? 255 : n;
        return DropEn ? cap : 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase    = PIdle;
        m_t0       = 0;
        m_n        = 0;
        m_drops    = 0;
        m_latched  = 1'b0;
        m_lok      = 1'b0;
        m_req_prev = 1'b0;
        m_hist     = '0;
    endfunction

    function automatic void model_step(bit link, bit req);
        bit rnew;
        int age;
        int k;
        rnew = req && !m_req_prev;
        age  = m_n - m_t0;
        case (m_phase)
            PIdle: begin
                if (rnew) begin
                    m_phase = PHold; m_t0 = m_n; m_latched = 1'b1;
                end else if (m_lok) begin
                    m_phase = PSeq; m_t0 = m_n;
                end
            end
            PSeq, PRun: begin
                if (!m_lok || rnew) begin
                    if (!m_lok) m_drops++;
                    m_phase = PHold; m_t0 = m_n; m_latched = rnew;
                end else if (m_phase == PSeq && age == int'(SD * NS + 1)) begin
                    m_phase = PRun;
                end
            end
            default: begin
                m_latched = m_latched | rnew;
                if (age == int'(SH)) begin
                    m_phase = PIdle; m_latched = 1'b0;
                end
            end
        endcase
        age     = m_n - m_t0;
        e_stage = '0;
        if (m_phase == PSeq) begin
            k = age / int'(SD);
            if (k > int'(NS)) k = NS;
            e_stage = NS'((1 << k) - 1);
        end else if (m_phase == PRun) begin
            e_stage = '1;
        end
        e_rdy = (m_phase == PRun);
        e_ack = (m_phase == PHold) && (age == int'(SH) - 1) && m_latched;
        // link_ok after this edge needs LD+1 high samples ending two edges back.
        m_req_prev = req;
        m_hist     = {m_hist[30:0], link};
        m_lok      = 1'b1;
        for (int i = 2; i <= int'(LD) + 2; i++) m_lok = m_lok & m_hist[i];
        m_n++;
    endfunction

    task automatic tick();
        logic [NS+9:0] act_v;
        logic [NS+9:0] exp_v;
        @(posedge core_clk);
        model_step(seq_if.smlh_link_up, seq_if.soft_rst_req);
        #1;
        if (seq_if.soft_rst_ack === 1'b1) ack_cnt++;
        act_v = {seq_if.stage_rst_n, seq_if.sys_ready, seq_if.soft_rst_ack, seq_if.link_drop_cnt};
        exp_v = {e_stage, e_rdy, e_ack, 8'(exp_drop(m_drops))};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL model cyc%0d: got %0h expected %0h", m_n - 1, act_v, exp_v);
        end
    endtask

    task automatic apply_reset(string tag);
        core_rst = 1'b1;
        #1;
        check({tag, "_stage"}, 32'(seq_if.stage_rst_n), 0);
        check({tag, "_ready"}, 32'(seq_if.sys_ready), 0);
        check({tag, "_ack"}, 32'(seq_if.soft_rst_ack), 0);
        check({tag, "_drops"}, 32'(seq_if.link_drop_cnt), 0);
        seq_if.smlh_link_up = 1'b0;
        seq_if.soft_rst_req = 1'b0;
        repeat (2) @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ack(input int start, output int took);
        took = start;
        while (seq_if.soft_rst_ack !== 1'b1 && took < 200) begin
            tick();
            took++;
        end
    endtask

    initial begin
        int n_ack;
        int took;
        int len;

        vecs[0]  = '{1'b1, 1'b0, 27, 3'b000, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1,  3'b001, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 15, 3'b001, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1,  3'b011, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 15, 3'b011, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1,  3'b111, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1,  3'b111, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b0, 3,  3'b111, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b0, 1,  3'b000, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 62, 3'b000, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b0, 10, 3'b000, 1'b0, 1'b0, 1};
        for (int r = 0; r < 7; r++) begin
            vecs[11 + r]       = vecs[r];
            vecs[11 + r].drops = 1;
        end

        seq_if.smlh_link_up = 1'b0;
        seq_if.soft_rst_req = 1'b0;
        #1;
        apply_reset("rst0");

        // Link up, staged release, drop in run, then resequence.
        for (int r = 0; r < 18; r++) begin
            seq_if.smlh_link_up = vecs[r].link;
            seq_if.soft_rst_req = vecs[r].req;
            repeat (vecs[r].ticks) tick();
            check($sformatf("vec%0d_stage", r), 32'(seq_if.stage_rst_n), 32'(vecs[r].stage));
            check($sformatf("vec%0d_ready", r), 32'(seq_if.sys_ready), 32'(vecs[r].rdy));
            check($sformatf("vec%0d_ack", r), 32'(seq_if.soft_rst_ack), 32'(vecs[r].ack));
            check($sformatf("vec%0d_drops", r), 32'(seq_if.link_drop_cnt),
                  32'(exp_drop(vecs[r].drops)));
        end

        // Short link glitch must not start sequencing.
        apply_reset("rst1");
        seq_if.smlh_link_up = 1'b1;
        repeat (5) tick();
        seq_if.smlh_link_up = 1'b0;
        repeat (30) tick();
        check("glitch_stage", 32'(seq_if.stage_rst_n), 0);
        check("glitch_drops", 32'(seq_if.link_drop_cnt), 0);

        // Soft request in run, held one extra cycle past ack.
        apply_reset("rst2");
        seq_if.smlh_link_up = 1'b1;
        repeat (61) tick();
        check("soft_run_ready", 32'(seq_if.sys_ready), 1);
        seq_if.soft_rst_req = 1'b1;
        n_ack = ack_cnt;
        tick();
        check("soft_stage_assert", 32'(seq_if.stage_rst_n), 0);
        wait_ack(0, took);
        check("soft_ack_latency", 32'(took), SH - 1);
        repeat (2) tick();
        seq_if.soft_rst_req = 1'b0;
        repeat (16) tick();
        check("soft_reseq_stage0", 32'(seq_if.stage_rst_n), 32'b001);
        check("soft_single_ack", 32'(ack_cnt - n_ack), 1);

        // Drop and request on the same edge, plus a second request inside the hold.
        apply_reset("rst3");
        seq_if.smlh_link_up = 1'b1;
        repeat (61) tick();
        seq_if.smlh_link_up = 1'b0;
        repeat (3) tick();
        seq_if.soft_rst_req = 1'b1;
        n_ack = ack_cnt;
        tick();
        check("both_stage_assert", 32'(seq_if.stage_rst_n), 0);
        check("both_drops", 32'(seq_if.link_drop_cnt), 32'(exp_drop(1)));
        repeat (10) tick();
        seq_if.soft_rst_req = 1'b0;
        repeat (10) tick();
        seq_if.soft_rst_req = 1'b1;
        wait_ack(20, took);
        check("both_ack_latency", 32'(took), SH - 1);
        seq_if.soft_rst_req = 1'b0;
        repeat (40) tick();
        check("both_single_ack", 32'(ack_cnt - n_ack), 1);
        check("both_drops_final", 32'(seq_if.link_drop_cnt), 32'(exp_drop(1)));

        // Asynchronous reset in the middle of staging.
        seq_if.smlh_link_up = 1'b1;
        repeat (44) tick();
        check("mid_stage_011", 32'(seq_if.stage_rst_n), 32'b011);
        #2;
        apply_reset("rst_mid");

        // Repeated drops saturate the counter.
        for (int d = 0; d < 300; d++) begin
            seq_if.smlh_link_up = 1'b1;
            repeat (13) tick();
            seq_if.smlh_link_up = 1'b0;
            repeat (70) tick();
        end
        check("drop_saturate", 32'(seq_if.link_drop_cnt), 32'(exp_drop(300)));

        // Random link and request activity against the model.
        apply_reset("rst4");
        for (int s = 0; s < 60; s++) begin
            seq_if.smlh_link_up = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 120);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) seq_if.soft_rst_req = ~seq_if.soft_rst_req;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
